pdpw_ram_gen: RTL
=================

# pdpw_ram_gen

Parametrised pseudo-dual-port block RAM: one write port with byte enables, one read port, a single clock domain. Successor to the fixed 18-bit-write EBR wrapper: generalised data width, depth and lane count, plus configurable read-during-write policy, an optional output register stage, and a post-reset memory-clear sequencer. Sits between datapath producers and consumers wherever a simple write-one/read-one buffer is needed.

## Interface
- DATA_WIDTH, 18: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 9: bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- DEPTH, 512: number of words, ≥ 2; AW = clog2(DEPTH).
- REGMODE, "NOREG": "NOREG" or "OUTREG" (extra DO pipeline stage gated by OCER).
- WRITE_MODE, "READBEFOREWRITE": same-address read/write policy, or "WRITETHROUGH".
- CSDECODE_W, 3'b000: CSW value that enables the write port.
- CSDECODE_R, 3'b000: CSR value that enables the read port.
- CLEAR_ON_RESET, 1: if 1, zero the whole array after reset release.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DI  in  DATA_WIDTH  write data.
- ADW  in  AW  write address.
- BE  in  NB  byte enables; lane i covers DI[i*BYTE_WIDTH +: BYTE_WIDTH].
- CEW  in  1  write clock enable.
- CSW  in  3  write chip select.
- ADR  in  AW  read address.
- CER  in  1  read clock enable.
- OCER  in  1  output-register enable (OUTREG only).
- CSR  in  3  read chip select.
- DO  out  DATA_WIDTH  read data.
- DO_VALID  out  1  DO holds data from an accepted read.
- BUSY  out  1  clear sequence in progress.

## Operation
- Write accepted (we) when CEW & (CSW == CSDECODE_W) & !BUSY & ADW < DEPTH; only lanes with BE[i]=1 are updated. Otherwise the write is dropped silently.
- Read accepted (re) when CER & (CSR == CSDECODE_R) & !BUSY. An out-of-range ADR returns 0.
- Same-address same-cycle read and write: in READBEFOREWRITE, the read returns the old word. In WRITETHROUGH, enabled lanes return DI and disabled lanes return the old contents (per-lane merge).
- Clear FSM states:
  - CLEAR (entered on RST when CLEAR_ON_RESET=1): writes 0 to address cnt, cnt increments from 0. At cnt == DEPTH-1 the FSM moves to READY.
  - READY: normal operation. With CLEAR_ON_RESET=0, the FSM resets directly into READY and array contents are undefined.
- RST asserted mid-clear or mid-operation: the FSM returns to CLEAR with cnt=0, and all in-flight reads are discarded.

## Timing
- Reset values:
  - DO = 0, DO_VALID = 0, pipeline register = 0.
  - BUSY = CLEAR_ON_RESET, clear counter = 0.
- Clear takes exactly DEPTH cycles after RST falls. BUSY drops at the edge that writes the last address, and the first read/write is accepted in the following cycle.
- NOREG: a read accepted at edge N gives DO/DO_VALID at edge N. DO holds its value when re=0, and DO_VALID falls to 0.
- OUTREG: stage 1 as NOREG (internal). Stage 2 loads DO/DO_VALID from stage 1 when OCER=1 and holds otherwise, so latency is 2 edges with OCER high.
- A write accepted at edge N is visible to a read of the same address accepted at edge N+1 in both modes.

## Structure
- Package pdpw_pkg holds:
  - regmode_t {NOREG, OUTREG} and wmode_t {RBW, WT};
  - CS_WIDTH = 3;
  - the clog2 function used for AW.
- Sub-module pdpw_mem_array holds the storage (DEPTH x DATA_WIDTH) with a per-lane write and a synchronous read-old-data port. Bypass merging, CS decode, the clear FSM and the output pipeline stay in pdpw_ram_gen.

## Test plan
- Clear sweep: DEPTH=16, CLEAR_ON_RESET=1; release RST → BUSY high 16 cycles, then reads of all 16 addresses return 0 with DO_VALID=1.
- Byte enables: write 18'h3FFFF to addr 5, then 18'h00000 with BE=2'b01 → read addr 5 gives 18'h3FE00.
- Collision: addr 7 holds 18'h12345; same-cycle write 18'h0ABCD with BE=2'b10 and read of addr 7. RBW gives 18'h12345; WT gives 18'h0AB45 (upper lane new, lower lane old).
- OUTREG: read addr 3 (value 18'h00AA5) with OCER=1 → DO valid 2 edges later. With OCER=0 on the second edge, DO holds its previous value until OCER rises.
- Chip select: CSDECODE_W=3'b101 with CSW=3'b100 write → memory unchanged. CSDECODE_R=3'b010 with CSR mismatch → DO_VALID stays 0.
- Reset mid-clear: assert RST at clear cycle 6 for 1 cycle → counter restarts, and BUSY lasts exactly DEPTH cycles after the second release.

Source files
------------

// File: rtl/pdpw_pkg.sv
// Shared types, constants and helpers for the pseudo-dual-port RAM generator.
package pdpw_pkg;

  typedef enum logic {NOREG, OUTREG} regmode_t;
  typedef enum logic {RBW, WT} wmode_t;
  typedef enum logic {CLEAR, READY} clr_state_t;

  localparam int CS_WIDTH = 3;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/pdpw_mem_array.sv
// DEPTH x DATA_WIDTH storage: per-lane write, synchronous read returning pre-write data.
module pdpw_mem_array #(
  parameter int DATA_WIDTH = 18,
  parameter int BYTE_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int AW         = 9,
  parameter int NB         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // the reset-visible output state lives in the wrapper instead.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pdpw_ram_gen.sv
// Parametrised pseudo-dual-port RAM: byte-enabled write port, read port with bypass policy,
// optional output register and a post-reset clear sequencer.
module pdpw_ram_gen
  import pdpw_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 18,
  parameter int                   BYTE_WIDTH     = 9,
  parameter int                   DEPTH          = 512,
  parameter string                REGMODE        = "NOREG",
  parameter string                WRITE_MODE     = "READBEFOREWRITE",
  parameter logic [CS_WIDTH-1:0]  CSDECODE_W     = 3'b000,
  parameter logic [CS_WIDTH-1:0]  CSDECODE_R     = 3'b000,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  localparam int                  NB             = DATA_WIDTH / BYTE_WIDTH,
  localparam int                  AW             = clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [AW-1:0]         ADW,
  input  logic [NB-1:0]         BE,
  input  logic                  CEW,
  input  logic [CS_WIDTH-1:0]   CSW,
  input  logic [AW-1:0]         ADR,
  input  logic                  CER,
  input  logic                  OCER,
  input  logic [CS_WIDTH-1:0]   CSR,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  DO_VALID,
  output logic                  BUSY
);

  localparam regmode_t   REG_MODE  = (REGMODE == "OUTREG") ? OUTREG : NOREG;
  localparam wmode_t     WMODE     = (WRITE_MODE == "WRITETHROUGH") ? WT : RBW;
  localparam clr_state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_t      state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic            busy, we, re, adr_ok;

  logic                  mem_we, mem_re;
  logic [AW-1:0]         mem_addr;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  logic [DATA_WIDTH-1:0] wt_mask, byp_mask, byp_data, s1_data, do_q;
  logic                  rd_valid, rd_zero, dov_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through the block leaves a variable unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST_ADDR) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state == CLEAR);
  assign BUSY   = busy;
  assign we     = CEW && (CSW == CSDECODE_W) && !busy && ({1'b0, ADW} < DEPTH_W);
  assign re     = CER && (CSR == CSDECODE_R) && !busy;
  assign adr_ok = ({1'b0, ADR} < DEPTH_W);

  // The clear sequencer borrows the write port while busy.
  assign mem_we    = we || busy;
  assign mem_addr  = busy ? cnt : ADW;
  assign mem_be    = busy ? '1 : BE;
  assign mem_wdata = busy ? '0 : DI;
  assign mem_re    = re && adr_ok;

  pdpw_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .NB         (NB)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_addr),
    .be    (mem_be),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (ADR),
    .rdata (mem_rdata)
  );

  // Write-through collision: enabled lanes of the incoming word override the old data.
  always_comb begin
    wt_mask = '0;
    if (WMODE == WT && we && ADR == ADW) begin
      for (int i = 0; i < NB; i++) wt_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{BE[i]}};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
      byp_mask <= '0;
      byp_data <= '0;
    end else begin
      rd_valid <= re;
      if (re) begin
        rd_zero  <= !adr_ok;
        byp_mask <= wt_mask;
        byp_data <= DI;
      end
    end
  end

  // rd_zero also hides the unreset array read register until the first read.
  assign s1_data = rd_zero ? '0 : ((mem_rdata & ~byp_mask) | (byp_data & byp_mask));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      do_q  <= '0;
      dov_q <= 1'b0;
    end else if (OCER) begin
      do_q  <= s1_data;
      dov_q <= rd_valid;
    end
  end

  assign DO       = (REG_MODE == OUTREG) ? do_q  : s1_data;
  assign DO_VALID = (REG_MODE == OUTREG) ? dov_q : rd_valid;

endmodule
